// File: rtl/fp_mul_param_seq.sv
// Parametrised sequential floating-point multiplier: flush-to-zero inputs, shift-add significand core.
// Optional macro FP_MUL_RNE_EN selects round-to-nearest-even; otherwise results truncate toward zero.

module fp_mul_param_seq #(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 23,
  parameter int RADIX_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 startFP,
  input  logic [EXP_W+MAN_W:0] Abus,
  input  logic [EXP_W+MAN_W:0] Bbus,
  output logic [EXP_W+MAN_W:0] Outbus,
  output logic                 doneFP,
  output logic                 busy,
  output logic [3:0]           flags
);
  localparam int W  = MAN_W + 1;
  localparam int N  = (W + RADIX_BITS - 1) / RADIX_BITS;
  localparam int MW = N * RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int XW = EXP_W + 2;
  localparam int FW = EXP_W + MAN_W + 1;
  localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, DONE} state_t;

  state_t         state;
  logic [FW-1:0]  a_q, b_q;
  logic           sign_q;
  logic [XW-1:0]  exp_q;
  logic [2*W-1:0] mcand_q, prod_q;
  logic [MW-1:0]  mplier_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   kept_q;
  logic           guard_q, sticky_q;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_inf  = (&ea) & ~|fa;
  assign b_inf  = (&eb) & ~|fb;
  assign a_nan  = (&ea) & |fa;
  assign b_nan  = (&eb) & |fb;

  logic          spec_hit, spec_inv;
  logic [FW-1:0] spec_out;

  always_comb begin
    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_out = '0;
    if (a_nan | b_nan) begin
      spec_out = QNAN;
    end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
      spec_out = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf | b_inf) begin
      spec_out = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      spec_out = {sa ^ sb, {(FW-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Partial product for the RADIX_BITS multiplier bits retired this cycle.
  logic [2*W-1:0] pp;

  always_comb begin
    pp = '0;
    for (int unsigned i = 0; i < RADIX_BITS; i++) begin
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    end
  end

  logic [W-1:0] norm_kept;
  logic         norm_guard, norm_sticky, norm_inc;

  always_comb begin
    if (prod_q[2*W-1]) begin
      norm_kept   = prod_q[2*W-1:W];
      norm_guard  = prod_q[W-1];
      norm_sticky = |prod_q[W-2:0];
      norm_inc    = 1'b1;
    end else begin
      norm_kept   = prod_q[2*W-2:W-1];
      norm_guard  = prod_q[W-2];
      norm_sticky = |prod_q[W-3:0];
      norm_inc    = 1'b0;
    end
  end

  logic [XW-1:0]    exp_r;
  logic [MAN_W-1:0] frac_r;
  logic             inexact_r, ovf_r, unf_r;
  logic             unused_bits;

`ifdef FP_MUL_RNE_EN
  logic         round_up;
  logic [W:0]   sum_r;

  // A carry out leaves sum_r[W-1:0] all zero, so the fraction clears on its own.
  assign round_up    = guard_q & (sticky_q | kept_q[0]);
  assign sum_r       = {1'b0, kept_q} + (W+1)'(round_up);
  assign exp_r       = exp_q + XW'(sum_r[W]);
  assign frac_r      = sum_r[MAN_W-1:0];
  assign unused_bits = sum_r[W-1];
`else
  assign exp_r       = exp_q;
  assign frac_r      = kept_q[MAN_W-1:0];
  assign unused_bits = kept_q[W-1];
`endif

  assign inexact_r = guard_q | sticky_q;
  assign ovf_r     = ~exp_r[XW-1] & (exp_r >= EMAX);
  assign unf_r     = exp_r[XW-1] | (exp_r == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      Outbus   <= '0;
      flags    <= '0;
      doneFP   <= 1'b0;
      busy     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      kept_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      doneFP <= 1'b0;
      case (state)
        IDLE: begin
          if (startFP) begin
            a_q   <= Abus;
            b_q   <= Bbus;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q <= sa ^ sb;
          if (spec_hit) begin
            Outbus <= spec_out;
            flags  <= {spec_inv, 3'b000};
            state  <= DONE;
          end else begin
            exp_q    <= XW'(ea) + XW'(eb) - BIAS;
            mcand_q  <= (2*W)'({1'b1, fa});
            mplier_q <= MW'({1'b1, fb});
            prod_q   <= '0;
            cnt_q    <= '0;
            state    <= MUL;
          end
        end
        MUL: begin
          prod_q   <= prod_q + pp;
          mcand_q  <= mcand_q << RADIX_BITS;
          mplier_q <= mplier_q >> RADIX_BITS;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) state <= NORM;
        end
        NORM: begin
          kept_q   <= norm_kept;
          guard_q  <= norm_guard;
          sticky_q <= norm_sticky;
          exp_q    <= exp_q + XW'(norm_inc);
          state    <= ROUND;
        end
        ROUND: begin
          if (ovf_r) begin
            Outbus <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags  <= 4'b0101;
          end else if (unf_r) begin
            Outbus <= {sign_q, {(FW-1){1'b0}}};
            flags  <= 4'b0011;
          end else begin
            Outbus <= {sign_q, exp_r[EXP_W-1:0], frac_r};
            flags  <= {3'b000, inexact_r};
          end
          state <= DONE;
        end
        DONE: begin
          doneFP <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
